// File: rtl/mc_pkg.sv
// Shared machine types: the input bundle's field types and the packed issue-queue entry.
package mc_pkg;

    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned REG_W    = 5;

    typedef logic [OPCODE_W-1:0] t_opcode;
    typedef logic [DATA_W-1:0]   t_data;
    typedef logic [REG_W-1:0]    t_reg_name;

    typedef struct packed {
        t_opcode   opcode;
        t_data     imm;
        t_reg_name src1;
        t_reg_name src2;
        t_reg_name dst;
    } t_inst;

endpackage

// File: rtl/iq_out_if.sv
// Output-side handshake bundle between the issue queue and decode.
interface iq_out_if;
    import mc_pkg::*;

    logic  out_valid;
    logic  out_ready;
    t_inst out_inst;

    modport driver   (output out_valid, output out_inst, input  out_ready);
    modport receiver (input  out_valid, input  out_inst, output out_ready);
endinterface

// File: rtl/iq_storage.sv
// Issue-queue entry array: one synchronous write port, one asynchronous read port, no reset.
module iq_storage
    import mc_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  t_inst                    wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output t_inst                    rdata
);

    t_inst mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_issue_queue.sv
// In-order instruction issue queue with flush, sticky overflow and a saturating drop counter.
module inst_issue_queue
    import mc_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned DROP_CNT_W = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     instv,
    input  t_opcode                  opcode,
    input  t_data                    imm,
    input  t_reg_name                src1,
    input  t_reg_name                src2,
    input  t_reg_name                dst,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output t_inst                    out_inst,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    output logic [DROP_CNT_W-1:0]    drop_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]      head_q;
    logic [PTR_W-1:0]      tail_q;
    logic [CNT_W-1:0]      count_q;
    logic                  overflow_q;
    logic [DROP_CNT_W-1:0] drop_cnt_q;
    logic                  loaded_q;

    logic  pop;
    logic  push;
    logic  drop;
    t_inst wdata;
    t_inst rdata;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign count     = count_q;
    assign out_valid = !empty;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;

    // Flush overrides any same-cycle push, pop or drop.
    assign pop  = out_valid && out_ready && !flush;
    assign push = instv && (!full || (out_valid && out_ready)) && !flush;
    assign drop = instv && full && !out_ready && !flush;

    assign wdata = '{opcode: opcode, imm: imm, src1: src1, src2: src2, dst: dst};

    iq_storage #(.DEPTH(DEPTH)) u_storage (
        .clock (clock),
        .we    (push),
        .waddr (tail_q),
        .wdata (wdata),
        .raddr (head_q),
        .rdata (rdata)
    );

    // Unwritten storage is hidden so out_inst reads zero out of reset.
    assign out_inst = loaded_q ? rdata : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                tail_q <= tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_q <= head_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // Overflow bookkeeping survives flush; only reset clears it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
            loaded_q   <= 1'b0;
        end else begin
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_cnt_q != '1) begin
                    drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
                end
            end
            if (push) begin
                loaded_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_inst_issue_queue.sv
// Directed bench for inst_issue_queue; a second instance with a 2-bit drop counter checks saturation.
module tb_inst_issue_queue;
    import mc_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic      clock;
    logic      reset;
    logic      instv;
    t_opcode   opcode;
    t_data     imm;
    t_reg_name src1;
    t_reg_name src2;
    t_reg_name dst;
    logic      flush;
    logic      out_ready;

    logic        out_valid;
    t_inst       out_inst;
    logic [2:0]  count;
    logic        full;
    logic        empty;
    logic        overflow;
    logic [7:0]  drop_cnt;

    logic        s_out_valid;
    t_inst       s_out_inst;
    logic [2:0]  s_count;
    logic        s_full;
    logic        s_empty;
    logic        s_overflow;
    logic [1:0]  s_drop_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    inst_issue_queue #(.DEPTH(DEPTH), .DROP_CNT_W(8)) dut (
        .clock(clock), .reset(reset), .instv(instv), .opcode(opcode), .imm(imm),
        .src1(src1), .src2(src2), .dst(dst), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .count(count), .full(full), .empty(empty), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    inst_issue_queue #(.DEPTH(DEPTH), .DROP_CNT_W(2)) dut_sat (
        .clock(clock), .reset(reset), .instv(instv), .opcode(opcode), .imm(imm),
        .src1(src1), .src2(src2), .dst(dst), .flush(flush),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_inst(s_out_inst),
        .count(s_count), .full(s_full), .empty(s_empty), .overflow(s_overflow),
        .drop_cnt(s_drop_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1 time unit after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input int op, input int im);
        instv  = v;
        opcode = OPCODE_W'(op);
        imm    = DATA_W'(im);
        src1   = REG_W'(op + 1);
        src2   = REG_W'(op + 2);
        dst    = REG_W'(op + 3);
    endtask

    task automatic push_one(input int op, input int im);
        drive(1'b1, op, im);
        tick();
        drive(1'b0, 0, 0);
    endtask

    int model[$];
    int hd;

    initial begin
        reset = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 0, 0);
        #12;
        check("rst_count",    64'(count), 64'd0);
        check("rst_empty",    64'(empty), 64'd1);
        check("rst_full",     64'(full), 64'd0);
        check("rst_valid",    64'(out_valid), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_drop",     64'(drop_cnt), 64'd0);
        check("rst_inst",     64'(out_inst), 64'd0);
        reset = 1'b1;
        tick();

        // Three pushes held with out_ready low, then drained in order.
        push_one(1, 'h10);
        check("lat_valid", 64'(out_valid), 64'd1);
        check("lat_op",    64'(out_inst.opcode), 64'd1);
        push_one(2, 'h20);
        push_one(3, 'h30);
        check("t1_count", 64'(count), 64'd3);
        tick();
        check("t1_hold_op",  64'(out_inst.opcode), 64'd1);
        check("t1_hold_imm", 64'(out_inst.imm), 64'h10);
        check("t1_hold_dst", 64'(out_inst.dst), 64'd4);
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            check($sformatf("t1_pop%0d", i), 64'(out_inst.opcode), 64'(i));
            tick();
        end
        check("t1_empty", 64'(empty), 64'd1);
        check("t1_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b0;

        // Overfill: entries 15,16 dropped, then 3 more drops to saturate the narrow counter.
        for (int i = 11; i <= 16; i++) begin
            push_one(i, i * 16);
            if (i == 14) begin
                check("t2_full",  64'(full), 64'd1);
                check("t2_count", 64'(count), 64'd4);
            end
        end
        check("t2_overflow", 64'(overflow), 64'd1);
        check("t2_drop",     64'(drop_cnt), 64'd2);
        check("t2_drop_s",   64'(s_drop_cnt), 64'd2);
        for (int i = 17; i <= 19; i++) push_one(i, 0);
        check("t4_drop",     64'(drop_cnt), 64'd5);
        check("t4_sat",      64'(s_drop_cnt), 64'd3);
        check("t4_count",    64'(count), 64'd4);

        // Full queue with simultaneous push and pop across pointer wrap.
        model = '{11, 12, 13, 14};
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 20 + i, 0);
            hd = model.pop_front();
            model.push_back(20 + i);
            check($sformatf("t3_pp%0d", i), 64'(out_inst.opcode), 64'(hd));
            tick();
            check($sformatf("t3_cnt%0d", i), 64'(count), 64'd4);
        end
        drive(1'b0, 0, 0);
        check("t3_drop", 64'(drop_cnt), 64'd5);
        for (int i = 0; i < 4; i++) begin
            hd = model.pop_front();
            check($sformatf("t3_drain%0d", i), 64'(out_inst.opcode), 64'(hd));
            tick();
        end
        check("t3_empty", 64'(empty), 64'd1);
        out_ready = 1'b0;

        // Flush at count 3 beats a same-cycle push and pop.
        push_one(31, 0);
        push_one(32, 0);
        push_one(33, 0);
        check("t5_count3", 64'(count), 64'd3);
        flush = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 34, 0);
        tick();
        flush = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 0, 0);
        check("t5_count", 64'(count), 64'd0);
        check("t5_empty", 64'(empty), 64'd1);
        check("t5_valid", 64'(out_valid), 64'd0);
        check("t5_ovf",   64'(overflow), 64'd1);
        check("t5_drop",  64'(drop_cnt), 64'd5);
        push_one(40, 'h400);
        check("t5_after_op", 64'(out_inst.opcode), 64'd40);
        check("t5_after_ct", 64'(count), 64'd1);

        // Asynchronous reset between edges with two entries queued.
        push_one(41, 0);
        check("t6_count2", 64'(count), 64'd2);
        #1;
        reset = 1'b0;
        #1;
        check("t6_count", 64'(count), 64'd0);
        check("t6_valid", 64'(out_valid), 64'd0);
        check("t6_ovf",   64'(overflow), 64'd0);
        check("t6_drop",  64'(drop_cnt), 64'd0);
        check("t6_inst",  64'(out_inst), 64'd0);
        #1;
        reset = 1'b1;
        tick();
        check("t6_idle_count", 64'(count), 64'd0);
        push_one(50, 'h55);
        check("t6_push_valid", 64'(out_valid), 64'd1);
        check("t6_push_op",    64'(out_inst.opcode), 64'd50);
        check("t6_push_imm",   64'(out_inst.imm), 64'h55);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
